pmem_line_responder: RTL and testbench

- Responder end of the cache-to-physical-memory line interface. Accepts 128-bit line read and line write requests from the cache (lc3b_line, 8 x lc3b_word).
- Performs each request as an 8-beat sequence of 16-bit word transfers on a word-wide memory port, acting as initiator on that port.
- Sits between the L1 cache's pmem port and the word-wide main memory / memory arbiter.

---
 rtl/pmem_line_responder.sv | 145 ++++++++++++++
 tb/tb_pmem_line_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: serves 128-bit cache line reads/writes as 8 word beats on a 16-bit memory port.
// Latency: request taken at edge 0, beats in cycles 1..8 (plus memory waits), pmem_resp pulses the cycle after the last beat.
// Backpressure: each beat waits indefinitely for mem_resp; the cache holds its request until pmem_resp.
//
// Ports:
//   clk, reset_n                      clock and asynchronous active-low reset
//   pmem_read/pmem_write/pmem_address line request from the cache (address bits [3:0] ignored)
//   pmem_wdata / pmem_rdata           128-bit lines, word i at bits [16i+15:16i]
//   pmem_resp                         one-cycle completion pulse
//   mem_read/mem_write/mem_address    word strobes and byte address towards memory
//   mem_wdata / mem_rdata / mem_resp  word data and per-beat completion from memory
module pmem_line_responder #(
  parameter int LINE_WORDS = 8,
  parameter int WORD_BYTES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [15:0]  mem_address,
  output logic [15:0]  mem_wdata,
  input  logic [15:0]  mem_rdata,
  input  logic         mem_resp
);

  localparam int CNT_W = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_BEAT = 2'd1,
    WR_BEAT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        base_q;
  logic [127:0]       wdata_q;
  logic [127:0]       rd_buf_q, rd_buf_d;
  logic [127:0]       rdata_q;
  logic               capture;
  logic               rd_done;
  logic               last_beat;
  logic [15:0]        beat_addr;

  // Lines never wrap: the highest beat is base + 14, which fits for every aligned base.
  assign beat_addr = base_q + (16'(count_q) * 16'(WORD_BYTES));
  assign last_beat = (count_q == CNT_W'(LINE_WORDS - 1));
  assign pmem_rdata = rdata_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_buf_d    = rd_buf_q;
    capture     = 1'b0;
    rd_done     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 16'h0000;
    mem_wdata   = 16'h0000;
    pmem_resp   = 1'b0;

    case (state_q)
      IDLE: begin
        // Write wins when both strobes are up; mem_resp is meaningless here.
        if (pmem_write) begin
          capture = 1'b1;
          count_d = '0;
          state_d = WR_BEAT;
        end else if (pmem_read) begin
          capture = 1'b1;
          count_d = '0;
          state_d = RD_BEAT;
        end
      end

      RD_BEAT: begin
        mem_read    = 1'b1;
        mem_address = beat_addr;
        if (mem_resp) begin
          rd_buf_d[count_q*16 +: 16] = mem_rdata;
          if (last_beat) begin
            count_d = '0;
            rd_done = 1'b1;
            state_d = RESP;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      WR_BEAT: begin
        mem_write   = 1'b1;
        mem_address = beat_addr;
        mem_wdata   = wdata_q[count_q*16 +: 16];
        if (mem_resp) begin
          if (last_beat) begin
            count_d = '0;
            state_d = RESP;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      RESP: begin
        pmem_resp = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      base_q   <= 16'h0000;
      wdata_q  <= '0;
      rd_buf_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_buf_q <= rd_buf_d;
      if (capture) begin
        base_q  <= pmem_address & 16'hFFF0;
        wdata_q <= pmem_wdata;
      end
      // Assemble in rd_buf and publish the whole line at once so pmem_rdata
      // keeps the previous line for the duration of the next read.
      if (rd_done) begin
        rdata_q <= rd_buf_d;
      end
    end
  end

endmodule

// File: tb/tb_pmem_line_responder.sv
module tb_pmem_line_responder;

  logic         clk;
  logic         reset_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;

  pmem_line_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers after n_wait stall cycles, combinationally on the final one.
  int          n_wait;
  int          wcnt;
  logic [15:0] rd_pat;
  logic        force_resp;

  always @(posedge clk) begin
    if ((mem_read || mem_write) && !mem_resp) wcnt <= wcnt + 1;
    else                                      wcnt <= 0;
  end

  always_comb begin
    mem_resp  = force_resp || ((mem_read || mem_write) && (wcnt == n_wait));
    mem_rdata = rd_pat + {13'b0, mem_address[3:1]};
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [15:0] p, input logic [15:0] step);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = p + 16'(i) * step;
    return l;
  endfunction

  // Per-transaction observations
  logic [15:0]  addr_q[$];
  logic [15:0]  wd_q[$];
  int           rd_cycles;
  int           wr_cycles;
  int           resp_n;
  int           resp_cyc;
  logic [127:0] resp_line;

  // Called at a negedge. Cycle k is the cycle after the k-th rising edge since the request.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [127:0] wd, input int waits, input logic poke_resp);
    int cyc;
    n_wait = waits;
    addr_q.delete();
    wd_q.delete();
    rd_cycles = 0;
    wr_cycles = 0;
    resp_n    = 0;
    resp_cyc  = -1;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    cyc = 0;
    while (cyc < 200 && !(resp_n > 0 && cyc >= resp_cyc + 2)) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      // Scribble on the request after acceptance; the latched copy must be used.
      if (cyc == 2) begin
        pmem_address = ~addr;
        pmem_wdata   = ~wd;
      end
      force_resp = 1'b0;
      if (mem_read)  rd_cycles++;
      if (mem_write) wr_cycles++;
      if (mem_resp && (mem_read || mem_write)) begin
        addr_q.push_back(mem_address);
        wd_q.push_back(mem_wdata);
      end
      if (pmem_resp) begin
        resp_n++;
        resp_cyc   = cyc;
        resp_line  = pmem_rdata;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        if (poke_resp) force_resp = 1'b1;
      end
    end
    if (resp_n == 0) chk("timeout_no_pmem_resp", 128'd0, 128'd1);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    force_resp = 1'b0;
  endtask

  task automatic chk_beats(input string tag, input logic [15:0] base,
                           input logic [127:0] line, input logic chk_data);
    logic [15:0] got;
    chk({tag, "_nbeats"}, 128'(addr_q.size()), 128'd8);
    for (int i = 0; i < 8; i++) begin
      got = (i < addr_q.size()) ? addr_q[i] : 16'hxxxx;
      chk($sformatf("%s_addr%0d", tag, i), 128'(got), 128'(16'(base + 16'(2*i))));
      if (chk_data) begin
        got = (i < wd_q.size()) ? wd_q[i] : 16'hxxxx;
        chk($sformatf("%s_wdata%0d", tag, i), 128'(got), 128'(line[i*16 +: 16]));
      end
    end
  endtask

  logic [127:0] line_a;
  logic [127:0] line_w;
  int           total_resp;
  int           stray;

  initial begin
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0;
    pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = 16'h0000; pmem_wdata = '0;
    n_wait = 0; rd_pat = 16'h0000; force_resp = 1'b0;

    #3;
    chk("rst_pmem_rdata", pmem_rdata, 128'd0);
    chk("rst_pmem_resp", 128'(pmem_resp), 128'd0);
    chk("rst_strobes", 128'({mem_read, mem_write}), 128'd0);
    chk("rst_mem_address", 128'(mem_address), 128'd0);
    chk("rst_mem_wdata", 128'(mem_wdata), 128'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Zero-wait read from 0x1236
    rd_pat = 16'hA000;
    line_a = mk_line(16'hA000, 16'h0001);
    run_txn(1'b1, 1'b0, 16'h1236, '0, 0, 1'b0);
    chk("rd1_resp_cycle", 128'(resp_cyc), 128'd9);
    chk("rd1_resp_pulses", 128'(resp_n), 128'd1);
    chk("rd1_rdata", resp_line, line_a);
    chk("rd1_read_cycles", 128'(rd_cycles), 128'd8);
    chk_beats("rd1", 16'h1230, '0, 1'b0);
    chk("rd1_rdata_hold", pmem_rdata, line_a);

    // Write to 0xFFF0 with 2 wait cycles per beat; mem_resp poked during RESP
    line_w = mk_line(16'h0000, 16'h0001);
    run_txn(1'b0, 1'b1, 16'hFFF0, line_w, 2, 1'b1);
    chk("wr_resp_cycle", 128'(resp_cyc), 128'd25);
    chk("wr_resp_pulses", 128'(resp_n), 128'd1);
    chk("wr_write_cycles", 128'(wr_cycles), 128'd24);
    chk("wr_read_cycles", 128'(rd_cycles), 128'd0);
    chk_beats("wr", 16'hFFF0, line_w, 1'b1);
    chk("wr_rdata_unchanged", pmem_rdata, line_a);

    // Both strobes: write wins, and the count restarted despite the RESP poke
    line_w = mk_line(16'h1000, 16'h1111);
    run_txn(1'b1, 1'b1, 16'h2009, line_w, 0, 1'b0);
    chk("both_read_cycles", 128'(rd_cycles), 128'd0);
    chk("both_write_cycles", 128'(wr_cycles), 128'd8);
    chk_beats("both", 16'h2000, line_w, 1'b1);

    // Reset during beat 4 of a read
    rd_pat = 16'hB000; n_wait = 0;
    pmem_address = 16'h0300; pmem_read = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_beat4_addr", 128'(mem_address), 128'(16'h0308));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_strobes", 128'({mem_read, mem_write}), 128'd0);
    chk("mid_rst_addr", 128'(mem_address), 128'd0);
    chk("mid_rst_rdata", pmem_rdata, 128'd0);
    chk("mid_rst_resp", 128'(pmem_resp), 128'd0);
    pmem_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (pmem_resp || mem_read || mem_write) stray++;
    end
    chk("post_rst_quiet", 128'(stray), 128'd0);
    rd_pat = 16'hC000;
    run_txn(1'b1, 1'b0, 16'h0440, '0, 0, 1'b0);
    chk("post_rst_rdata", resp_line, mk_line(16'hC000, 16'h0001));
    chk_beats("post_rst", 16'h0440, '0, 1'b0);

    // Back-to-back reads, second line must fully replace the first
    rd_pat = 16'h1100;
    run_txn(1'b1, 1'b0, 16'h5000, '0, 1, 1'b0);
    total_resp = resp_n;
    chk("b2b_first_rdata", resp_line, mk_line(16'h1100, 16'h0001));
    rd_pat = 16'h7700;
    run_txn(1'b1, 1'b0, 16'h5010, '0, 0, 1'b0);
    total_resp += resp_n;
    chk("b2b_resp_total", 128'(total_resp), 128'd2);
    chk("b2b_second_rdata", pmem_rdata, mk_line(16'h7700, 16'h0001));

    // mem_resp while idle: nothing moves, next read starts at word 0
    force_resp = 1'b1;
    stray = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (pmem_resp || mem_read || mem_write) stray++;
    end
    force_resp = 1'b0;
    chk("idle_poke_quiet", 128'(stray), 128'd0);
    rd_pat = 16'h3300;
    run_txn(1'b1, 1'b0, 16'h0100, '0, 0, 1'b0);
    chk("idle_poke_resp_cycle", 128'(resp_cyc), 128'd9);
    chk_beats("idle_poke", 16'h0100, '0, 1'b0);
    chk("idle_poke_rdata", resp_line, mk_line(16'h3300, 16'h0001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
